// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word type and the instruction-cache geometry,
// frame layout and controller state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_TAG_W = 26;
    localparam int ICACHE_IDX_W = 4;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

    // Frame index: word-address bits just above the byte offset.
    function automatic logic [ICACHE_IDX_W-1:0] icache_idx(input word_t addr);
        return addr[ICACHE_IDX_W+1:2];
    endfunction

    // Tag: everything above the index.
    function automatic logic [ICACHE_TAG_W-1:0] icache_tag(input word_t addr);
        return addr[31:ICACHE_IDX_W+2];
    endfunction

endpackage

// File: rtl/icache_if.sv
// Instruction-cache bus bundle: datapath request/response, memory-side
// read channel and the statistics outputs.
interface icache_if;
    import cpu_types_pkg::*;

    // datapath side
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  flush;
    // memory side
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    // statistics
    word_t hit_count;
    word_t miss_count;

    // cache view
    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    // environment view (datapath + memory)
    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 16 one-word frames, blocking on miss.
// Optional statistics counters are built when ICACHE_STATS_EN is defined;
// otherwise hit_count/miss_count are tied to zero.
module icache
    import cpu_types_pkg::*;
(
    input logic     CLK,
    input logic     nRST,
    icache_if.slave cif
);

    icache_state_t state_q, state_d;
    word_t         miss_addr_q, miss_addr_d;

    logic [ICACHE_SETS-1:0]  valid_q;
    logic [ICACHE_TAG_W-1:0] tag_q  [ICACHE_SETS];
    word_t                   data_q [ICACHE_SETS];

    logic [ICACHE_IDX_W-1:0] req_idx, fill_idx;
    logic [ICACHE_TAG_W-1:0] req_tag;
    icache_frame_t           lookup;
    logic                    lookup_hit;

    logic  ihit, iren, fill_en, miss_start;
    word_t imemload, iaddr;

    assign req_idx  = icache_idx(cif.imemaddr);
    assign req_tag  = icache_tag(cif.imemaddr);
    assign fill_idx = icache_idx(miss_addr_q);

    assign lookup = '{valid: valid_q[req_idx], tag: tag_q[req_idx], data: data_q[req_idx]};
    assign lookup_hit = lookup.valid && (lookup.tag == req_tag);

    // Controller state and latched miss address; reset abandons any fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Next state, lookup response and memory request. The fill always targets
    // miss_addr_q, so the datapath may change imemaddr while we wait.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit        = 1'b0;
        imemload    = '0;
        iren        = 1'b0;
        iaddr       = '0;
        fill_en     = 1'b0;
        miss_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cif.imemREN && !cif.flush) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = lookup.data;
                    end else begin
                        miss_start  = 1'b1;
                        miss_addr_d = cif.imemaddr;
                        state_d     = MISS;
                    end
                end
            end
            MISS: begin
                iren  = 1'b1;
                iaddr = {miss_addr_q[31:2], 2'b00};
                if (cif.flush) begin
                    // flush wins over a completing fill: nothing is written
                    state_d = IDLE;
                end else if (!cif.iwait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid bits: cleared by reset or flush, set by a completed fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (cif.flush) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= icache_tag(miss_addr_q);
            data_q[fill_idx] <= cif.iload;
        end
    end

    assign cif.ihit     = ihit;
    assign cif.imemload = imemload;
    assign cif.iREN     = iren;
    assign cif.iaddr    = iaddr;

`ifdef ICACHE_STATS_EN
    word_t hit_count_q, miss_count_q;

    // Free-running statistics; only reset clears them, flush does not.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (ihit)       hit_count_q  <= hit_count_q + 32'd1;
            if (miss_start) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign cif.hit_count  = hit_count_q;
    assign cif.miss_count = miss_count_q;

    // byte-offset bits carry no information for word fetches
    logic unused_bits;
    assign unused_bits = ^{cif.imemaddr[1:0], miss_addr_q[1:0]};
`else
    assign cif.hit_count  = '0;
    assign cif.miss_count = '0;

    // byte-offset bits and the miss event have no consumer in this build
    logic unused_bits;
    assign unused_bits = ^{cif.imemaddr[1:0], miss_addr_q[1:0], miss_start};
`endif

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameters: none; geometry SHALL come from package constants ICACHE_SETS=16, ICACHE_TAG_W=26, ICACHE_IDX_W=4.
REQ-002 CLK  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 imemREN  in  1  datapath instruction read request.
REQ-005 imemaddr  in  32  byte address of the requested instruction; bits [1:0] ignored.
REQ-006 ihit  out  1  imemload valid for imemaddr this cycle.
REQ-007 imemload  out  32  instruction word.
REQ-008 flush  in  1  invalidate all frames.
REQ-009 iREN  out  1  memory-side read request.
REQ-010 iaddr  out  32  memory-side word address.
REQ-011 iwait  in  1  memory busy; iload valid in the cycle iwait=0 while iREN=1.
REQ-012 iload  in  32  memory read data.
REQ-013 hit_count, miss_count  out  32 each  statistics (see Configuration).

Function
REQ-014 Organisation: direct-mapped, 16 one-word frames {valid, tag[25:0], data[31:0]}; index=imemaddr[5:2], tag=imemaddr[31:6].
REQ-015 States: IDLE, MISS.
REQ-016 IDLE: ihit=imemREN & valid[idx] & (tag[idx]==addr tag), combinational, same cycle; imemload=data[idx] on hit, else 0.
REQ-017 IDLE, imemREN=1, lookup miss, flush=0 -> latch imemaddr into miss_addr, go to MISS next edge.
REQ-018 MISS: iREN=1, iaddr={miss_addr[31:2],2'b00}, ihit=0; stay while iwait=1.
REQ-019 MISS, iwait=0 -> write frame[miss_addr idx] = {1, miss_addr tag, iload}, go to IDLE; hit visible next cycle (miss latency = memory latency + 1 cycle).
REQ-020 imemaddr changing during MISS SHALL NOT redirect the fill; fill completes at miss_addr, then IDLE re-evaluates the new address.
REQ-021 imemREN=0 in IDLE: ihit=0, no state change, iREN=0.
REQ-022 flush=1: all valid bits clear at next edge; in IDLE ihit forced 0 that cycle; in MISS the fill is aborted (no frame write even if iwait=0 same cycle), next state IDLE.
REQ-023 iREN SHALL be 0 in IDLE; iaddr SHALL be 0 when iREN=0.
REQ-024 Replacement: fill overwrites the indexed frame unconditionally.

Reset
REQ-025 nRST low SHALL immediately force state IDLE, all valid=0, miss_addr=0, counters=0, ihit=0, iREN=0, iaddr=0, imemload=0; tag/data arrays need not reset.
REQ-026 Reset during MISS SHALL abandon the fill; no frame written.

Configuration
REQ-027 Macro ICACHE_STATS_EN defined: hit_count +1 each cycle ihit=1; miss_count +1 on each IDLE->MISS transition; both wrap modulo 2^32; flush does not clear them.
REQ-028 ICACHE_STATS_EN undefined: counter registers absent, hit_count=miss_count=0 constantly; all other behaviour identical.

Structure
REQ-029 cpu_types_pkg SHALL hold ICACHE_SETS, ICACHE_TAG_W, ICACHE_IDX_W, typedef icache_frame_t (packed valid/tag/data), typedef icache_state_t enum {IDLE, MISS}; word_t reused for 32-bit buses.
REQ-030 No sub-module; frame array, FSM and counters inline in icache.

Verification
REQ-031 Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, memory 2-cycle iwait, iload=0x2008_0005 -> iREN=1 for 3 cycles, iaddr=0x40, ihit=1 with imemload=0x2008_0005 the cycle after fill; miss_count=1.
REQ-032 Hit then conflict: after 031, addr 0x40 -> ihit same cycle; addr 0x0000_0080 (same idx 0, new tag) -> miss, refill, then 0x40 misses again; miss_count=3.
REQ-033 Flush mid-miss: miss on 0x0000_0104, assert flush with iwait=0 same cycle -> no frame write, state IDLE, re-request 0x104 misses again.
REQ-034 Address change during MISS: miss on 0x10, switch imemaddr to 0x20 while iwait=1 -> iaddr stays 0x10, frame idx 4 filled, then 0x20 misses.
REQ-035 Async reset: nRST low mid-MISS between edges -> iREN=0, ihit=0 immediately; after release, 0x10 misses.
REQ-036 Stats off: rebuild without ICACHE_STATS_EN, run 031-032 -> identical ihit/iREN traces, counters 0.
